// File: rtl/n_clic_ret.sv
// Interrupt return stack for n_clic: saves {return PC, threshold} on entry and
// restores both when the fetch PC reaches the magic exit address.
module n_clic_ret #(
  parameter int IMemAddrWidth = 10,
  parameter int AddrWidth     = IMemAddrWidth,
  parameter int PrioWidth     = 3,
  parameter int Depth         = 8,
  parameter logic [AddrWidth-1:0] ExitAddr = {AddrWidth{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [AddrWidth-1:0]   push_pc,
  input  logic [PrioWidth-1:0]   push_thresh,
  input  logic [AddrWidth-1:0]   pc_in,
  input  logic [AddrWidth-1:0]   pc_next_in,
  output logic [AddrWidth-1:0]   pc_out,
  output logic                   restore_valid,
  output logic [PrioWidth-1:0]   thresh_restore,
  output logic [$clog2(Depth):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int IdxWidth   = $clog2(Depth);
  localparam int LevelWidth = IdxWidth + 1;

  logic [AddrWidth-1:0]  stack_pc     [Depth];
  logic [PrioWidth-1:0]  stack_thresh [Depth];

  logic                  exit;
  logic [LevelWidth-1:0] level_dec;
  logic [IdxWidth-1:0]   top_idx;
  logic [IdxWidth-1:0]   wr_idx;
  logic                  do_push;
  logic                  do_pop;
  logic                  set_ovf;
  logic                  set_unf;

  assign exit      = (pc_in == ExitAddr);
  assign full      = (level == LevelWidth'(Depth));
  assign empty     = (level == {LevelWidth{1'b0}});
  assign level_dec = level - LevelWidth'(1);
  assign top_idx   = level_dec[IdxWidth-1:0];
  assign wr_idx    = level[IdxWidth-1:0];

  // Cycle classification and the zero-latency PC / threshold override.
  always_comb begin
    pc_out        = pc_next_in;
    restore_valid = 1'b0;
    do_push       = 1'b0;
    do_pop        = 1'b0;
    set_ovf       = 1'b0;
    set_unf       = 1'b0;
    if (empty) begin
      thresh_restore = {PrioWidth{1'b0}};
    end else begin
      thresh_restore = stack_thresh[top_idx];
    end
    case ({push, exit})
      2'b10: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          do_push = 1'b1;
        end
      end
      2'b01: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          do_pop        = 1'b1;
          pc_out        = stack_pc[top_idx];
          restore_valid = 1'b1;
        end
      end
      // Tail-chain: the original return context stays on top untouched.
      2'b11: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          set_unf = 1'b0;
        end
      end
      default: begin
        do_push = 1'b0;
      end
    endcase
  end

  // Nesting level and sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level     <= {LevelWidth{1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        level <= level + LevelWidth'(1);
      end else if (do_pop) begin
        level <= level_dec;
      end
      overflow  <= set_ovf | (overflow  & ~clr_err);
      underflow <= set_unf | (underflow & ~clr_err);
    end
  end

  // Context storage; contents are meaningless above the current level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_pc[wr_idx]     <= push_pc;
      stack_thresh[wr_idx] <= push_thresh;
    end
  end

endmodule

// File: tb/tb_n_clic_ret.sv
// Scoreboard bench for n_clic_ret: a queue-based return-stack model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_n_clic_ret;
  localparam int AW = 8;
  localparam int PW = 3;
  localparam int D  = 8;
  localparam logic [AW-1:0] EXIT = 8'hFF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic [AW-1:0] push_pc = 8'h00;
  logic [PW-1:0] push_thresh = 3'd0;
  logic [AW-1:0] pc_in = 8'h00;
  logic [AW-1:0] pc_next_in = 8'h00;
  logic [AW-1:0] pc_out;
  logic          restore_valid;
  logic [PW-1:0] thresh_restore;
  logic [3:0]    level;
  logic          full, empty, overflow, underflow;
  logic          clr_err = 1'b0;

  n_clic_ret #(.IMemAddrWidth(AW), .AddrWidth(AW), .PrioWidth(PW), .Depth(D), .ExitAddr(EXIT)) dut (
    .clk(clk), .reset(reset), .push(push), .push_pc(push_pc), .push_thresh(push_thresh),
    .pc_in(pc_in), .pc_next_in(pc_next_in), .pc_out(pc_out), .restore_valid(restore_valid),
    .thresh_restore(thresh_restore), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: return contexts as plain queues, top at the back.
  int  m_pc[$];
  int  m_th[$];
  bit  m_ovf = 0;
  bit  m_unf = 0;

  logic [19:0] exp_q[$];

  function automatic logic [19:0] pack(logic [AW-1:0] p, logic rv, logic [PW-1:0] tr,
                                       logic [3:0] lv, logic f, logic e, logic o, logic u);
    return {p, rv, tr, lv, f, e, o, u};
  endfunction

  task automatic step(input logic p, input logic [AW-1:0] ppc, input logic [PW-1:0] pth,
                      input logic [AW-1:0] pin, input logic [AW-1:0] pnx, input logic clr);
    int n;
    bit ex, so, su;
    logic [AW-1:0] e_pc;
    logic [PW-1:0] e_tr;
    logic e_rv;
    @(posedge clk);
    #1;
    push = p; push_pc = ppc; push_thresh = pth; pc_in = pin; pc_next_in = pnx; clr_err = clr;
    n = m_pc.size();
    ex = (pin == EXIT);
    e_pc = pnx;
    e_rv = 1'b0;
    e_tr = (n > 0) ? PW'(m_th[n-1]) : 3'd0;
    if (ex && !p && n > 0) begin
      e_pc = AW'(m_pc[n-1]);
      e_rv = 1'b1;
    end
    exp_q.push_back(pack(e_pc, e_rv, e_tr, 4'(n), n == D, n == 0, m_ovf, m_unf));
    so = 0; su = 0;
    if (p && !ex) begin
      if (n == D) so = 1;
      else begin m_pc.push_back(int'(ppc)); m_th.push_back(int'(pth)); end
    end else if (ex && !p) begin
      if (n == 0) su = 1;
      else begin void'(m_pc.pop_back()); void'(m_th.pop_back()); end
    end else if (ex && p && n == 0) begin
      su = 1;
    end
    m_ovf = so | (m_ovf & !clr);
    m_unf = su | (m_unf & !clr);
  endtask

  task automatic idle(input logic [AW-1:0] pnx);
    step(1'b0, 8'h00, 3'd0, 8'h00, pnx, 1'b0);
  endtask

  // Monitor: every cycle with an outstanding prediction is compared mid-cycle.
  always @(negedge clk) begin
    logic [19:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_out, restore_valid, thresh_restore, level, full, empty, overflow, underflow};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t {pc,rv,thr,lvl,full,empty,ovf,unf} actual=%h expected=%h",
                 $time, a, e);
      end
    end
  end

  initial begin
    int r;
    logic p, ex;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    idle(8'd5);
    // Two nested entries, then two exits.
    step(1'b1, 8'd10, 3'd0, 8'h00, 8'd40, 1'b0);
    step(1'b1, 8'd33, 3'd1, 8'h00, 8'd41, 1'b0);
    idle(8'd6);
    step(1'b0, 8'd0, 3'd0, EXIT, 8'd7, 1'b0);
    step(1'b0, 8'd0, 3'd0, EXIT, 8'd8, 1'b0);
    idle(8'd9);
    // Fill to depth plus one overflowing push, then drain.
    for (int i = 1; i <= 9; i++) step(1'b1, AW'(i), PW'(i), 8'h00, 8'd50, 1'b0);
    idle(8'd11);
    for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 3'd0, EXIT, 8'd12, 1'b0);
    step(1'b0, 8'd0, 3'd0, 8'h00, 8'd13, 1'b1);
    // Exit on empty stack, then clear.
    step(1'b0, 8'd0, 3'd0, EXIT, 8'd14, 1'b0);
    idle(8'd15);
    step(1'b0, 8'd0, 3'd0, 8'h00, 8'd16, 1'b1);
    idle(8'd17);
    // Tail-chain keeps the original return context.
    step(1'b1, 8'd20, 3'd2, 8'h00, 8'd60, 1'b0);
    step(1'b1, 8'd99, 3'd4, EXIT, 8'd56, 1'b0);
    idle(8'd18);
    step(1'b0, 8'd0, 3'd0, EXIT, 8'd19, 1'b0);
    // Tail-chain on empty stack plus error-vs-clear priority.
    step(1'b1, 8'd77, 3'd5, EXIT, 8'd21, 1'b1);
    idle(8'd22);
    step(1'b0, 8'd0, 3'd0, 8'h00, 8'd23, 1'b1);

    // Asynchronous reset with three contexts stacked.
    for (int i = 0; i < 3; i++) step(1'b1, AW'(30 + i), PW'(i), 8'h00, 8'd24, 1'b0);
    idle(8'd25);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL async_reset actual level=%0d empty=%b full=%b required level=0 empty=1 full=0",
               level, empty, full);
    end
    m_pc.delete(); m_th.delete(); m_ovf = 0; m_unf = 0;
    @(negedge clk);
    #2;
    reset = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      p = (r < 45);
      ex = ($urandom_range(0, 99) < 40);
      step(p, AW'($urandom_range(0, 254)), PW'($urandom_range(0, 7)),
           ex ? EXIT : AW'($urandom_range(0, 254)), AW'($urandom_range(0, 255)),
           ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
